// File: rtl/sram_bus_ctrl_if.sv
// Host-side bus of the SRAM controller: the serial address load, the request/ack
// handshake and the status outputs.
interface sram_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 8
);
  logic                  si;
  logic                  sreg_en_n;
  logic                  auto_inc;
  logic                  rd_req;
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] cur_addr;

  modport master (
    output si, sreg_en_n, auto_inc, rd_req, wr_req, wdata,
    input  rdata, ack, busy, cur_addr
  );

  modport slave (
    input  si, sreg_en_n, auto_inc, rd_req, wr_req, wdata,
    output rdata, ack, busy, cur_addr
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// SRAM bus controller: a timed host access engine (setup/strobe/hold) sharing the
// SRAM with a read-only SNES passthrough selected by a mode latch.
module sram_bus_ctrl #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  snes_mode,
  sram_bus_ctrl_if.slave        host,
  input  logic [ADDR_WIDTH-1:0] snes_addr,
  input  logic                  snes_rd_n,
  output logic [DATA_WIDTH-1:0] snes_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_dout_en,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_ce_n
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  logic [2:0]            state;
  logic [3:0]            cnt;
  logic                  op_wr;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] snes_q;
  logic                  start;
  logic                  active;

  assign start = (state == IDLE) && !mode && (host.wr_req || host.rd_req);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      mode    <= 1'b0;
      addr    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      snes_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!host.sreg_en_n)
            addr <= {addr[ADDR_WIDTH-2:0], host.si};
          if (start) begin
            state   <= SETUP;
            cnt     <= SETUP_LD;
            op_wr   <= host.wr_req;
            wdata_q <= host.wdata;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            state <= STROBE;
            cnt   <= STROBE_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            if (!op_wr)
              rdata_q <= sram_din;
            if (HOLD_CYC == 0) begin
              state <= DONE;
            end else begin
              state <= HOLD;
              cnt   <= HOLD_LD;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0)
            state <= DONE;
          else
            cnt <= cnt - 4'd1;
        end
        DONE: begin
          state <= IDLE;
          if (host.auto_inc)
            addr <= addr + 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Sampling on the DONE->IDLE edge makes a mid-access mode change visible on
      // the very first idle cycle; an accepted request holds the latch for its access.
      if (((state == IDLE) && !start) || (state == DONE))
        mode <= snes_mode;

      if (mode && !snes_rd_n)
        snes_q <= sram_din;
    end
  end

  assign active = (state == SETUP) || (state == STROBE) || (state == HOLD);

  always_comb begin
    sram_addr    = addr;
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_dout_en = 1'b0;
    if (mode) begin
      sram_addr = snes_addr;
      sram_ce_n = snes_rd_n;
      sram_oe_n = snes_rd_n;
    end else begin
      sram_ce_n    = !active;
      sram_oe_n    = !((state == STROBE) && !op_wr);
      sram_we_n    = !((state == STROBE) && op_wr);
      sram_dout_en = active && op_wr;
    end
  end

  assign sram_dout     = wdata_q;
  assign snes_data     = snes_q;
  assign host.rdata    = rdata_q;
  assign host.ack      = (state == DONE);
  assign host.busy     = (state != IDLE);
  assign host.cur_addr = addr;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Randomized bench for sram_bus_ctrl: an SRAM device model on the pins plus a
// reference of the address register and memory contents derived from the access rules.
module tb_sram_bus_ctrl;
  localparam int AW = 21;
  localparam int DW = 8;
  localparam int S  = 1;
  localparam int T  = 2;
  localparam int H  = 1;
  localparam int LAT = 1 + S + T + H;
  localparam int unsigned AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          snes_mode = 1'b0;
  logic [AW-1:0] snes_addr = '0;
  logic          snes_rd_n = 1'b1;
  logic [DW-1:0] snes_data;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din = '0;
  logic [DW-1:0] sram_dout;
  logic          sram_dout_en, sram_oe_n, sram_we_n, sram_ce_n;

  sram_bus_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_bus_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SETUP_CYC(S), .STROBE_CYC(T), .HOLD_CYC(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .snes_mode(snes_mode), .host(bus),
    .snes_addr(snes_addr), .snes_rd_n(snes_rd_n), .snes_data(snes_data),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout),
    .sram_dout_en(sram_dout_en), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ce_n(sram_ce_n)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int viol    = 0;

  logic [DW-1:0] dev_mem [int unsigned];
  logic [DW-1:0] pre_mem [int unsigned];
  logic [DW-1:0] ref_mem [int unsigned];
  int unsigned   exp_addr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] background(input int unsigned a);
    if (pre_mem.exists(a)) return pre_mem[a];
    return DW'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  function automatic logic [DW-1:0] dev_rd(input int unsigned a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return background(a);
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return background(a);
  endfunction

  // SRAM device: latches writes while we_n is low, presents read data for the address.
  always @(negedge clk) begin
    if (reset_n) begin
      if (!sram_oe_n && !sram_we_n) viol++;
      if (sram_dout_en && !sram_oe_n) viol++;
    end
    if (!sram_we_n) dev_mem[int'(sram_addr)] = sram_dout;
    sram_din = dev_rd(int'(sram_addr));
  end

  task automatic shift_addr(input int unsigned v, input int nbits, input bit host_mode);
    int bad = 0;
    logic [31:0] vv;
    vv = v;
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      if (host_mode && !(sram_ce_n && sram_oe_n && sram_we_n)) bad++;
      bus.si = vv[i];
      bus.sreg_en_n = 1'b0;
      exp_addr = ((exp_addr << 1) | int'(vv[i])) & AMASK;
    end
    @(negedge clk);
    bus.sreg_en_n = 1'b1;
    check("shift_addr", 32'(bus.cur_addr), exp_addr);
    if (host_mode) check("shift_strobes_high", bad, 0);
  endtask

  task automatic host_access(input bit wr, input bit rd, input logic [DW-1:0] wd,
                             input bit inc, input int mode_at, input string tag);
    int n = 0, ce = 0, we = 0, oe = 0;
    logic [DW-1:0] seen = '0;
    int unsigned a;
    a = exp_addr;
    @(negedge clk);
    bus.wr_req = wr; bus.rd_req = rd; bus.wdata = wd; bus.auto_inc = inc;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (n == mode_at) snes_mode = 1'b1;
      if (!sram_ce_n) ce++;
      if (!sram_we_n) begin we++; seen = sram_dout; end
      if (!sram_oe_n) oe++;
      if (bus.ack) break;
    end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check({tag, "_ack_lat"}, n, LAT);
    check({tag, "_ce_cycles"}, ce, S + T + H);
    if (wr) begin
      check({tag, "_we_cycles"}, we, T);
      check({tag, "_oe_cycles"}, oe, 0);
      check({tag, "_wdata_pins"}, 32'(seen), 32'(wd));
      ref_mem[a] = wd;
    end else begin
      check({tag, "_oe_cycles"}, oe, T);
      check({tag, "_we_cycles"}, we, 0);
      check({tag, "_rdata"}, 32'(bus.rdata), 32'(ref_rd(a)));
    end
    if (inc) exp_addr = (exp_addr + 1) % (1 << AW);
    @(negedge clk);
    check({tag, "_ack_pulse"}, 32'(bus.ack), 0);
    check({tag, "_cur_addr"}, 32'(bus.cur_addr), exp_addr);
  endtask

  initial begin
    int acks;
    bit w, r;
    bus.si = 1'b0; bus.sreg_en_n = 1'b1; bus.auto_inc = 1'b0;
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.wdata = '0;

    #12;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_cur_addr", 32'(bus.cur_addr), 0);
    check("rst_strobes", {29'd0, sram_oe_n, sram_we_n, sram_ce_n}, 32'h7);
    check("rst_dout_en", 32'(sram_dout_en), 0);
    check("rst_snes_data", 32'(snes_data), 0);
    @(negedge clk);
    reset_n = 1'b1;

    shift_addr(32'h1ABCDE, AW, 1'b1);

    shift_addr(32'h000010, AW, 1'b1);
    host_access(1'b1, 1'b0, 8'hA5, 1'b1, 0, "wr_a5");
    check("wr_a5_dev_mem", 32'(dev_rd(32'h10)), 32'hA5);

    pre_mem[32'h1FFFFF] = 8'h3C;
    shift_addr(32'h1FFFFF, AW, 1'b1);
    host_access(1'b0, 1'b1, 8'h00, 1'b1, 0, "rd_wrap");
    check("rd_wrap_rdata_3c", 32'(bus.rdata), 32'h3C);

    shift_addr(32'h000200, AW, 1'b1);
    host_access(1'b1, 1'b1, 8'h55, 1'b0, 0, "both_req");
    check("both_req_dev_mem", 32'(dev_rd(32'h200)), 32'h55);

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 0)
        shift_addr($urandom_range(0, 31) + (($urandom_range(0, 1) == 1) ? 32'h1FFFE0 : 32'h0), AW, 1'b1);
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      host_access(w, r, 8'($urandom), 1'($urandom_range(0, 1)), 0, "rand");
    end

    pre_mem[32'h012345] = 8'h77;
    snes_addr = 21'h012345;
    shift_addr(32'h000300, AW, 1'b1);
    host_access(1'b1, 1'b0, 8'hC3, 1'b0, 2, "snes_mid");
    check("snes_sram_addr", 32'(sram_addr), 32'h012345);
    check("snes_we_high", 32'(sram_we_n), 1);
    check("snes_dout_en", 32'(sram_dout_en), 0);
    snes_rd_n = 1'b0;
    @(negedge clk);
    check("snes_oe_follows", {30'd0, sram_oe_n, sram_ce_n}, 0);
    check("snes_data", 32'(snes_data), 32'h77);
    acks = 0;
    bus.rd_req = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack || bus.busy) acks++;
    end
    bus.rd_req = 1'b0;
    check("snes_no_host_ack", acks, 0);
    shift_addr(32'h5, 3, 1'b0);
    snes_rd_n = 1'b1;
    snes_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("host_mode_back", 32'(sram_addr), exp_addr);

    shift_addr(32'h000123, AW, 1'b1);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wdata = 8'h99; bus.auto_inc = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_we_low", 32'(sram_we_n), 0);
    ref_mem[32'h123] = 8'h99;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_we_high", 32'(sram_we_n), 1);
    check("rst_mid_dout_en", 32'(sram_dout_en), 0);
    check("rst_mid_ce_high", 32'(sram_ce_n), 1);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_cur_addr", 32'(bus.cur_addr), 0);
    exp_addr = 0;
    bus.wr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ack) acks++;
    end
    check("rst_mid_no_ack", acks, 0);
    check("rst_mid_addr_after", 32'(bus.cur_addr), exp_addr);

    check("oe_we_dout_exclusive", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end
endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
Parametrised SRAM bus controller for the cartridge CPLD. It replaces the fixed 21-bit/8-bit shift-register plus bus FSM arrangement with one timed access engine.
- Host side (AVR): serial address load, auto-increment, and a read/write request/acknowledge handshake with programmable strobe timing.
- SNES side: when snes_mode is asserted, the SRAM is handed to the SNES address bus as a read-only passthrough.
- The block sits between the command decoder and the SRAM pins.

Parameters:
ADDR_WIDTH, 21, SRAM/SNES address width in bits
DATA_WIDTH, 8, data bus width in bits
SETUP_CYC, 1, clk cycles of address/data setup before a strobe (1..15)
STROBE_CYC, 2, clk cycles the oe_n/we_n strobe is held low (1..15)
HOLD_CYC, 1, clk cycles of address/data hold after strobe release (0..15)

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset_n  in  1  asynchronous active-low reset
snes_mode  in  1  1 = SNES owns the SRAM; 0 = host owns the SRAM
si  in  1  serial address bit, shifted MSB first
sreg_en_n  in  1  low = shift si into the address register this cycle
auto_inc  in  1  1 = increment the address after each completed host access
rd_req  in  1  host read request, level held until ack
wr_req  in  1  host write request, level held until ack
wdata  in  DATA_WIDTH  host write data
rdata  out  DATA_WIDTH  host read data, registered
ack  out  1  one-cycle pulse marking a completed host access
busy  out  1  high whenever the FSM is not in IDLE
cur_addr  out  ADDR_WIDTH  current host address register
snes_addr  in  ADDR_WIDTH  SNES address bus
snes_rd_n  in  1  SNES read strobe
snes_data  out  DATA_WIDTH  data returned to the SNES
sram_addr  out  ADDR_WIDTH  SRAM address pins
sram_din  in  DATA_WIDTH  SRAM data bus, input path
sram_dout  out  DATA_WIDTH  SRAM data bus, output path
sram_dout_en  out  1  tristate enable for sram_dout (1 = drive)
sram_oe_n, sram_we_n, sram_ce_n  out  1 each  SRAM control strobes, active low

Behaviour:
- Reset values:
  - FSM in IDLE; address register = 0; rdata = 0; ack = 0; busy = 0.
  - sram_oe_n = sram_we_n = sram_ce_n = 1; sram_dout_en = 0; snes_data = 0; internal mode latch = host.
  - Reset asserted mid-access aborts the access immediately and returns all outputs to these values.
- Address register:
  - In IDLE, when sreg_en_n = 0: addr <= {addr[ADDR_WIDTH-2:0], si}.
  - Shifting is ignored while busy = 1.
- Mode latch:
  - snes_mode is sampled into the mode latch only in IDLE.
  - A change while busy takes effect on the first cycle back in IDLE.
- SNES mode (latched):
  - sram_addr = snes_addr; sram_ce_n = sram_oe_n = snes_rd_n; sram_we_n = 1; sram_dout_en = 0.
  - snes_data is a registered copy of sram_din, captured every clk while snes_rd_n = 0. Latency is 1 clk.
  - Host rd_req/wr_req are not accepted (no ack), and the address register still shifts.
- Host mode:
  - sram_addr = addr register; snes_data holds its last value.
  - FSM states: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE.
  - Request selection (IDLE): wr_req wins over rd_req when both are high. The chosen operation and wdata are latched on the IDLE->SETUP edge.
  - SETUP: lasts SETUP_CYC cycles. ce_n = 0. For writes, dout_en = 1 and sram_dout = latched wdata.
  - STROBE: lasts STROBE_CYC cycles. A read drives oe_n = 0; a write drives we_n = 0. For reads, rdata <= sram_din on the final STROBE cycle.
  - HOLD: lasts HOLD_CYC cycles with strobes high and ce_n = 0. HOLD_CYC = 0 skips this state.
  - DONE: lasts 1 cycle. ack = 1, ce_n = 1, dout_en = 0. If auto_inc = 1, addr <= addr + 1, wrapping from 2^ADDR_WIDTH-1 to 0.
  - After DONE the FSM returns to IDLE. A request still high in IDLE starts a new access, so back-to-back requests are allowed.
  - Total latency from request to ack = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles. With defaults, ack is high 5 cycles after the request is sampled.
- sram_we_n and sram_oe_n are never low in the same cycle. sram_dout_en is never 1 while oe_n = 0.
- A single timing counter of 4 bits is used.

Test Plan:
- Reset, then shift 21 bits of 0x1ABCDE (MSB first) with sreg_en_n = 0 -> cur_addr = 0x1ABCDE. All strobes stay high throughout.
- Host write of wdata = 0xA5 at 0x000010 with defaults, auto_inc = 1 -> ce_n low for 4 cycles, we_n low for exactly 2 cycles, sram_dout = 0xA5, ack on cycle 5, cur_addr = 0x000011.
- Host read with sram_din model returning 0x3C at 0x1FFFFF, auto_inc = 1 -> oe_n low for 2 cycles, rdata = 0x3C at ack, cur_addr wraps to 0x000000.
- rd_req and wr_req asserted together, wdata = 0x55 -> write performed, single ack, no oe_n pulse.
- snes_mode raised mid-write -> write completes and acks. Next cycle sram_addr follows snes_addr = 0x012345. With snes_rd_n = 0 and sram_din = 0x77, snes_data = 0x77 one clk later, and host rd_req gets no ack.
- reset_n pulsed low during STROBE of a write -> we_n returns high asynchronously, dout_en = 0, no ack, cur_addr = 0.
